// File: rtl/agc_fetch_sequencer_if.sv
// Instruction-fetch memory bus between the fetch sequencer and program memory.
//   mem_req   : fetch request, level, held until mem_ack
//   mem_addr  : fetch address (the sequencer's Z register)
//   mem_rdata : fetched word, valid in the mem_ack cycle
//   mem_ack   : one-cycle fetch completion
// master = sequencer side, slave = memory side.
interface agc_fetch_sequencer_if;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned WORD_W = 15;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/agc_fetch_sequencer.sv
// AGC-style instruction fetch sequencer.
// Fetches the word at Z, folds EXTEND prefixes into an extracode flag,
// hands the instruction to decode with a one-cycle strobe, then waits for
// the execute unit (optionally taking a branch) before the next fetch.
// A fetch that is not acknowledged within TIMEOUT cycles parks the block
// in a sticky FAULT state that only reset clears.
//
// Ports:
//   tp            clock, rising edge
//   rst_n         synchronous active-low reset
//   run           permits starting new instruction fetches
//   mem           fetch bus (master side): mem_req/mem_addr out, mem_rdata/mem_ack in
//   instr_out     latched instruction word for decode
//   extend        instr_out is an extracode
//   decode_strobe one-cycle pulse: instr_out/extend valid
//   exec_done     execute unit finished current instruction
//   branch_valid  qualifies branch_addr, sampled with exec_done
//   branch_addr   next-instruction address on branch
//   z_out         program counter Z
//   fault         sticky memory-timeout flag
//   state_out     current state encoding (IDLE=0 FETCH=1 DECODE=2 EXEC=3 FAULT=4)
module agc_fetch_sequencer #(
    parameter logic [11:0] RESET_ADDR  = 12'o4000,
    parameter int unsigned TIMEOUT     = 15,
    parameter logic [14:0] EXTEND_WORD = 15'o00006
) (
    input  logic                         tp,
    input  logic                         rst_n,
    input  logic                         run,
    agc_fetch_sequencer_if.master        mem,
    output logic [14:0]                  instr_out,
    output logic                         extend,
    output logic                         decode_strobe,
    input  logic                         exec_done,
    input  logic                         branch_valid,
    input  logic [11:0]                  branch_addr,
    output logic [11:0]                  z_out,
    output logic                         fault,
    output logic [2:0]                   state_out
);

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned WORD_W = 15;
    localparam int unsigned TMO_W  = 4;

    // Last counter value before the fault fires: the TIMEOUT-th FETCH cycle
    // without mem_ack sees the counter at TIMEOUT-1.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  z;
    logic               mem_req_q;
    logic               ext_pending;
    logic [TMO_W-1:0]   tmo_cnt;

    // Sequencer: state, program counter, fetch request and decode outputs.
    always_ff @(posedge tp) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            z             <= RESET_ADDR;
            mem_req_q     <= 1'b0;
            instr_out     <= '0;
            extend        <= 1'b0;
            ext_pending   <= 1'b0;
            decode_strobe <= 1'b0;
            fault         <= 1'b0;
            tmo_cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state     <= ST_FETCH;
                        mem_req_q <= 1'b1;
                        tmo_cnt   <= '0;
                    end
                end

                ST_FETCH: begin
                    // An ack always wins over a timeout in the same cycle.
                    if (mem.mem_ack) begin
                        tmo_cnt <= '0;
                        z       <= z + ADDR_W'(1);
                        if (mem.mem_rdata == EXTEND_WORD) begin
                            // Prefix only: keep requesting the following word.
                            ext_pending <= 1'b1;
                        end else begin
                            instr_out     <= mem.mem_rdata;
                            extend        <= ext_pending;
                            ext_pending   <= 1'b0;
                            decode_strobe <= 1'b1;
                            mem_req_q     <= 1'b0;
                            state         <= ST_DECODE;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        mem_req_q <= 1'b0;
                        fault     <= 1'b1;
                        state     <= ST_FAULT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                ST_DECODE: begin
                    decode_strobe <= 1'b0;
                    state         <= ST_EXEC;
                end

                ST_EXEC: begin
                    // run is only consulted here, so a dropped run never
                    // aborts the instruction in flight.
                    if (exec_done) begin
                        if (branch_valid) begin
                            z <= branch_addr;
                        end
                        if (run) begin
                            state     <= ST_FETCH;
                            mem_req_q <= 1'b1;
                            tmo_cnt   <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end

                ST_FAULT: begin
                    // Sticky until reset; run and the bus are ignored.
                    mem_req_q <= 1'b0;
                    fault     <= 1'b1;
                end

                default: begin
                    state         <= ST_IDLE;
                    mem_req_q     <= 1'b0;
                    decode_strobe <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = z;
    assign z_out        = z;
    assign state_out    = state;

    // Word width of the bus matches the instruction register.
    localparam int unsigned INSTR_W_CHECK = WORD_W;
    if (INSTR_W_CHECK != $bits(instr_out)) begin : g_width_mismatch
        $error("instr_out width does not match bus word width");
    end

endmodule

// File: tb/tb_agc_fetch_sequencer.sv
// Bench for agc_fetch_sequencer: acts as program memory and execute unit,
// tracking expected Z / instruction / extracode state transaction by transaction.
`timescale 1ns/1ps
module tb_agc_fetch_sequencer;

    localparam logic [14:0] EXT_W = 15'o00006;
    localparam logic [11:0] RST_A = 12'o4000;

    logic        tp = 1'b0;
    logic        rst_n;
    logic        run;
    logic        exec_done;
    logic        branch_valid;
    logic [11:0] branch_addr;
    logic [14:0] instr_out;
    logic        extend;
    logic        decode_strobe;
    logic [11:0] z_out;
    logic        fault;
    logic [2:0]  state_out;

    agc_fetch_sequencer_if bus();

    agc_fetch_sequencer #(
        .RESET_ADDR  (RST_A),
        .TIMEOUT     (15),
        .EXTEND_WORD (EXT_W)
    ) dut (
        .tp            (tp),
        .rst_n         (rst_n),
        .run           (run),
        .mem           (bus),
        .instr_out     (instr_out),
        .extend        (extend),
        .decode_strobe (decode_strobe),
        .exec_done     (exec_done),
        .branch_valid  (branch_valid),
        .branch_addr   (branch_addr),
        .z_out         (z_out),
        .fault         (fault),
        .state_out     (state_out)
    );

    always #5 tp = ~tp;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: architectural view of the sequencer.
    logic [11:0] m_z;
    logic        m_ext;
    logic [14:0] m_instr;
    logic        m_extend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; exec_done = 1'b0; branch_valid = 1'b0;
        branch_addr = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        repeat (2) @(negedge tp);
        chk("rst_state",  32'(state_out),     32'd0);
        chk("rst_z",      32'(z_out),         32'(RST_A));
        chk("rst_req",    32'(bus.mem_req),   32'd0);
        chk("rst_instr",  32'(instr_out),     32'd0);
        chk("rst_extend", 32'(extend),        32'd0);
        chk("rst_strobe", 32'(decode_strobe), 32'd0);
        chk("rst_fault",  32'(fault),         32'd0);
        rst_n = 1'b1;
        m_z = RST_A; m_ext = 1'b0; m_instr = '0; m_extend = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (bus.mem_req !== 1'b1 && n < 20) begin
            @(negedge tp);
            n++;
        end
        chk("req_seen", 32'(bus.mem_req), 32'd1);
    endtask

    // One fetch transaction: ack after lat idle FETCH cycles with word w.
    task automatic fetch(input int lat, input logic [14:0] w, input logic run_f);
        wait_req();
        chk("mem_addr", 32'(bus.mem_addr), 32'(m_z));
        run = run_f;
        for (int i = 0; i < lat; i++) begin
            bus.mem_ack  = 1'b0;
            exec_done    = 1'($urandom);
            branch_valid = 1'b1;
            branch_addr  = 12'($urandom);
            @(negedge tp);
            chk("fetch_hold", 32'({state_out, bus.mem_req, decode_strobe}), 32'({3'd1, 1'b1, 1'b0}));
        end
        exec_done = 1'b0; branch_valid = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = w;
        @(negedge tp);
        bus.mem_ack = 1'b0; bus.mem_rdata = 15'($urandom);
        m_z = m_z + 12'd1;
        if (w == EXT_W) begin
            m_ext = 1'b1;
            chk("ext_stay", 32'({state_out, bus.mem_req, decode_strobe}), 32'({3'd1, 1'b1, 1'b0}));
        end else begin
            m_instr = w; m_extend = m_ext; m_ext = 1'b0;
            chk("decode", 32'({state_out, bus.mem_req, decode_strobe}), 32'({3'd2, 1'b0, 1'b1}));
        end
        chk("instr_out", 32'(instr_out), 32'(m_instr));
        chk("extend",    32'(extend),    32'(m_extend));
        chk("z_out",     32'(z_out),     32'(m_z));
        chk("no_fault",  32'(fault),     32'd0);
    endtask

    // Execute phase: idle cycles with stray acks, then exec_done.
    task automatic exec(input int idle, input logic bv, input logic [11:0] ba, input logic run_after);
        logic [3:0] exp_nx;
        @(negedge tp);
        chk("exec_entry", 32'({state_out, decode_strobe}), 32'({3'd3, 1'b0}));
        run = run_after;
        for (int i = 0; i < idle; i++) begin
            bus.mem_ack = 1'($urandom); bus.mem_rdata = 15'($urandom);
            @(negedge tp);
            chk("exec_wait", 32'({state_out, bus.mem_req}), 32'({3'd3, 1'b0}));
            chk("exec_z",    32'(z_out), 32'(m_z));
        end
        bus.mem_ack = 1'b0;
        exec_done = 1'b1; branch_valid = bv; branch_addr = ba;
        @(negedge tp);
        exec_done = 1'b0; branch_valid = 1'b0;
        if (bv) m_z = ba;
        exp_nx = run_after ? {3'd1, 1'b1} : {3'd0, 1'b0};
        chk("exec_next",  32'({state_out, bus.mem_req}), 32'(exp_nx));
        chk("exec_z_out", 32'(z_out),     32'(m_z));
        chk("instr_hold", 32'(instr_out), 32'(m_instr));
    endtask

    task automatic restart(input int gap);
        for (int i = 0; i < gap; i++) begin
            @(negedge tp);
            chk("idle", 32'({state_out, bus.mem_req}), 32'({3'd0, 1'b0}));
        end
        run = 1'b1;
    endtask

    initial begin
        do_reset();
        run = 1'b1;

        // Plain fetch from the reset address, ack after two waiting cycles.
        fetch(2, 15'o30005, 1'b1);
        exec(1, 1'b0, 12'd0, 1'b1);

        // EXTEND prefix then extracode; Z advances by two.
        fetch(0, EXT_W, 1'b1);
        fetch(1, 15'o10017, 1'b1);
        chk("z_plus2", 32'(z_out), 32'(12'o4003));
        exec(2, 1'b1, 12'o2000, 1'b1);

        // Branch target used, then sequential Z+1.
        fetch(0, 15'o20001, 1'b1);
        exec(0, 1'b0, 12'd0, 1'b1);
        fetch(1, 15'o20002, 1'b1);

        // Z wraps from FFF to 000.
        exec(0, 1'b1, 12'hFFF, 1'b1);
        fetch(0, 15'o11111, 1'b1);
        chk("z_wrap", 32'(z_out), 32'd0);

        // run dropped during a multi-EXTEND fetch: fetch completes, prefix retained.
        exec(1, 1'b0, 12'd0, 1'b1);
        fetch(3, EXT_W, 1'b0);
        fetch(2, EXT_W, 1'b0);
        fetch(1, 15'o22222, 1'b0);
        exec(0, 1'b0, 12'd0, 1'b1);

        // Ack on the 15th FETCH cycle is still in time.
        fetch(14, 15'o33333, 1'b1);

        // run low during EXEC: instruction completes, then IDLE.
        exec(2, 1'b0, 12'd0, 1'b0);
        restart(3);

        // Randomized instruction stream.
        for (int k = 0; k < 40; k++) begin
            logic [14:0] w;
            logic        ra;
            w  = ($urandom_range(0, 3) == 0) ? EXT_W : 15'($urandom);
            fetch(int'($urandom_range(0, 5)), w, 1'($urandom));
            if (w != EXT_W) begin
                ra = ($urandom_range(0, 4) != 0);
                exec(int'($urandom_range(0, 3)), 1'($urandom), 12'($urandom), ra);
                if (!ra) restart(int'($urandom_range(0, 2)));
            end
        end

        // Timeout: 15 FETCH cycles without ack -> FAULT.
        run = 1'b1;
        wait_req();
        for (int i = 0; i < 14; i++) begin
            @(negedge tp);
            chk("tmo_wait", 32'({state_out, bus.mem_req}), 32'({3'd1, 1'b1}));
        end
        @(negedge tp);
        chk("fault_state", 32'({state_out, bus.mem_req, fault}), 32'({3'd4, 1'b0, 1'b1}));
        for (int i = 0; i < 3; i++) begin
            bus.mem_ack = 1'b1; bus.mem_rdata = 15'($urandom); exec_done = 1'b1;
            @(negedge tp);
            chk("fault_sticky", 32'({state_out, bus.mem_req, fault}), 32'({3'd4, 1'b0, 1'b1}));
            chk("fault_z",      32'(z_out), 32'(m_z));
        end
        bus.mem_ack = 1'b0; exec_done = 1'b0;

        // Reset clears the fault; then reset in the middle of a fetch.
        do_reset();
        run = 1'b1;
        fetch(0, 15'o12345, 1'b1);
        exec(0, 1'b1, 12'o1234, 1'b1);
        wait_req();
        chk("pre_rst_addr", 32'(bus.mem_addr), 32'(12'o1234));
        @(negedge tp);
        rst_n = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 15'o30005;
        @(negedge tp);
        chk("midrst", 32'({state_out, bus.mem_req}), 32'({3'd0, 1'b0}));
        chk("midrst_z", 32'(z_out), 32'(RST_A));
        chk("midrst_instr", 32'({instr_out, extend}), 32'd0);
        rst_n = 1'b1; run = 1'b0;
        @(negedge tp);
        bus.mem_ack = 1'b0;
        chk("late_ack", 32'({state_out, bus.mem_req}), 32'({3'd0, 1'b0}));
        chk("late_ack_z", 32'(z_out), 32'(RST_A));
        chk("late_ack_instr", 32'(instr_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/agc_fetch_sequencer.md
AGC_FETCH_SEQUENCER -- requirements
Module: agc_fetch_sequencer

Interface
REQ-001 Parameter RESET_ADDR, 12'o4000, Z value loaded at reset (fresh-start address).
REQ-002 Parameter TIMEOUT, 15, max FETCH cycles waiting for mem_ack before fault (range 1..15).
REQ-003 Parameter EXTEND_WORD, 15'o00006, fetched word treated as EXTEND prefix.
REQ-004 tp  input  1  clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 run  input  1  level; permits starting new instruction fetches.
REQ-007 mem_req  output  1  fetch request, level, held until mem_ack.
REQ-008 mem_addr  output  12  fetch address, equals Z while mem_req=1.
REQ-009 mem_rdata  input  15  fetched word, valid in the mem_ack cycle.
REQ-010 mem_ack  input  1  one-cycle fetch completion.
REQ-011 instr_out  output  15  latched instruction word for the decode unit.
REQ-012 extend  output  1  instr_out is an extracode.
REQ-013 decode_strobe  output  1  one-cycle pulse: instr_out/extend valid, decode now.
REQ-014 exec_done  input  1  execute unit finished current instruction.
REQ-015 branch_valid  input  1  qualifies branch_addr, sampled with exec_done.
REQ-016 branch_addr  input  12  next-instruction address on branch.
REQ-017 z_out  output  12  program counter Z.
REQ-018 fault  output  1  sticky memory-timeout flag.
REQ-019 state_out  output  3  current state encoding, for debug.

Function
REQ-020 States SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, FAULT=4, driven on state_out.
REQ-021 IDLE: go to FETCH when run=1; otherwise stay.
REQ-022 FETCH: mem_req=1, mem_addr=Z; timeout counter increments each cycle without mem_ack.
REQ-023 FETCH with mem_ack=1, word != EXTEND_WORD: instr_out<=mem_rdata, extend<=ext_pending, ext_pending<=0, Z<=Z+1, go DECODE.
REQ-024 FETCH with mem_ack=1, word == EXTEND_WORD: ext_pending<=1, Z<=Z+1, stay FETCH, timeout counter cleared; no decode_strobe; consecutive EXTENDs leave ext_pending=1.
REQ-025 Timeout counter SHALL clear on every mem_ack and on entering FETCH; reaching TIMEOUT without mem_ack goes FAULT.
REQ-026 mem_ack and timeout in the same cycle: mem_ack wins.
REQ-027 mem_ack outside FETCH SHALL be ignored.
REQ-028 DECODE: decode_strobe=1 for exactly this one cycle; always go EXEC next.
REQ-029 EXEC: wait for exec_done; exec_done outside EXEC ignored.
REQ-030 EXEC with exec_done=1: if branch_valid, Z<=branch_addr, else Z unchanged; go FETCH if run=1, else IDLE.
REQ-031 Z increment SHALL wrap 12'hFFF -> 12'h000.
REQ-032 FAULT: mem_req=0, fault=1; stay until reset; run ignored.
REQ-033 run deasserted mid-instruction SHALL NOT abort it; only the next fetch is withheld.
REQ-034 run deasserted during FETCH: the request still completes; ext_pending retained.
REQ-035 mem_req SHALL drop in the cycle after the accepting mem_ack unless staying in FETCH (EXTEND).
REQ-036 instr_out and extend SHALL hold from DECODE until the next non-EXTEND fetch completes.

Reset
REQ-037 rst_n=0 at an edge, in any state: state=IDLE, Z=RESET_ADDR, mem_req=0, instr_out=0, extend=0, ext_pending=0, decode_strobe=0, fault=0, timeout counter=0.
REQ-038 Reset during pending fetch SHALL drop mem_req next edge; a late mem_ack is ignored.
REQ-039 Outputs SHALL be defined (no X) from the first edge with rst_n=0.

Verification
REQ-040 Reset, run=1, ack word 15'o30005 after 2 cycles -> mem_addr=12'o4000, instr_out=15'o30005, extend=0, one decode_strobe, Z=12'o4001.
REQ-041 Fetch 15'o00006 then 15'o10017 -> no strobe for first, strobe with extend=1, Z advanced by 2; next plain instruction gives extend=0.
REQ-042 exec_done with branch_valid=1, branch_addr=12'o2000 -> next mem_addr=12'o2000; with branch_valid=0 -> Z+1 used.
REQ-043 Z=12'hFFF, fetch acked -> Z=12'h000.
REQ-044 No mem_ack for 15 FETCH cycles -> FAULT, fault=1, mem_req=0; ack on cycle 15 -> no fault.
REQ-045 run=0 during EXEC -> instruction completes, IDLE, no new mem_req; reset asserted during FETCH -> IDLE, Z=12'o4000.
